k_encode_logic: RTL and testbench
=================================

# k_encode_logic

Operand-pair-to-instruction encoder: the inverse of the DSP instruction decoder. It accepts (rs1, rs2) operand pairs over a valid/ready handshake and maps each pair to the 32-bit instruction code that the decoder expands back into the same pair. It buffers encoded instructions in a small FIFO and issues them downstream over a second valid/ready handshake. It sits upstream of the decoder in the K_DSP instruction path and counts operand pairs that have no legal encoding.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of the miss counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept a pair this cycle
- in_rs1  in  32  first operand
- in_rs2  in  32  second operand
- out_valid  out  1  head-of-FIFO instruction valid
- out_ready  in  1  downstream consumes the head this cycle
- out_instruction  out  32  encoded instruction at FIFO head
- out_miss  out  1  head entry came from an unencodable pair
- clr_count  in  1  synchronous clear of miss_count
- miss_count  out  CNT_W  saturating count of unencodable pairs accepted
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Encoding map (rs1, rs2 → instruction): (1, 15)→1; (15, 7)→2; (7, 3)→3; (3, 1)→4; (0, 0)→0 (legal, out_miss=0).
- Any other pair → instruction 0 with miss=1. Full 32-bit equality on both operands.
- Accept = in_valid && in_ready. On accept, {miss, instruction} is pushed into the FIFO.
- in_ready = (level < DEPTH). There is no same-cycle pop-through when full: a full FIFO deasserts in_ready even if out_ready=1.
- Pop = out_valid && out_ready. out_valid = (level != 0).
- The FIFO is first-word-fall-through. out_instruction/out_miss show the head entry whenever out_valid=1, and are held stable until popped.
- Push and pop in the same cycle: level is unchanged and pointers wrap modulo DEPTH.
- miss_count increments on each accept with miss=1 and saturates at all-ones.
- clr_count=1 clears miss_count to 0 at the next edge. clr_count takes priority over a simultaneous increment, and that miss is not counted.
- in_rs1/in_rs2 are sampled only on accept. Operand values while in_valid=0 have no effect.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - out_valid=0, out_instruction=0, out_miss=0
  - level=0, miss_count=0
  - in_ready=1
  - FIFO pointers to 0
- Reset asserted mid-operation discards all buffered entries, and no partial pop is reported.
- First rising edge after rst_n deasserts is a normal cycle.
- Latency: a pair accepted at edge N into an empty FIFO drives out_valid=1 with its code from edge N to edge N+1 (one cycle).
- Throughput: one accept and one pop per cycle sustained, provided level < DEPTH.
- in_ready and out_valid are decoded from registered level only, with no combinational path from in_valid or out_ready.
- miss_count updates at the accept edge, so it is visible the cycle after the accept.

## Structure
- Shared package k_dsp_pkg holds:
  - instruction code constants K_INSTR_NOP=0 … K_INSTR_4=4
  - per-code operand constants K_RS1_n / K_RS2_n
  - function k_encode(rs1, rs2) returning {miss, instr}
- The existing decoder is to be migrated onto the same constants so both directions share one table.
- One sub-module, k_sync_fifo, parameterised by width (33) and DEPTH, provides push/pop/level/full/empty.
- The encoder proper (compare, counter, handshake glue) stays in k_encode_logic.

## Test plan
- Reset then idle: after rst_n release, in_ready=1, out_valid=0, level=0, miss_count=0, out_instruction=0.
- Stream the four legal pairs (1,15),(7,3),(15,7),(3,1) with out_ready=1:
  - outputs 1,3,2,4 in order, each one cycle after accept
  - out_miss=0, miss_count stays 0
- Backpressure, out_ready=0:
  - 4 accepts make level=4 and in_ready=0; a 5th in_valid is not accepted.
  - Then out_ready=1 for one cycle with in_valid=1: pop only, level=3.
  - Next cycle push+pop leaves level=3.
- Misses:
  - pairs (5,5),(0,0),(1,14) produce codes 0,0,0 with out_miss 1,0,1, and miss_count=2
  - clr_count asserted on the same cycle as a third miss gives miss_count=0
- Saturation, with CNT_W=4: 17 unencodable pairs leave miss_count at 15.
- Reset mid-stream: with level=3, pulse rst_n low asynchronously (between edges).
  - Outputs clear immediately, level=0.
  - After release, a new pair (15,7) emerges as 2 with no stale entries.

Source files
------------

// File: rtl/k_dsp_pkg.sv
// rtl/k_dsp_pkg.sv - shared K_DSP instruction codes, operand table and encode function
package k_dsp_pkg;

  localparam logic [31:0] K_INSTR_NOP = 32'd0;
  localparam logic [31:0] K_INSTR_1   = 32'd1;
  localparam logic [31:0] K_INSTR_2   = 32'd2;
  localparam logic [31:0] K_INSTR_3   = 32'd3;
  localparam logic [31:0] K_INSTR_4   = 32'd4;

  localparam logic [31:0] K_RS1_NOP = 32'd0;
  localparam logic [31:0] K_RS2_NOP = 32'd0;
  localparam logic [31:0] K_RS1_1   = 32'd1;
  localparam logic [31:0] K_RS2_1   = 32'd15;
  localparam logic [31:0] K_RS1_2   = 32'd15;
  localparam logic [31:0] K_RS2_2   = 32'd7;
  localparam logic [31:0] K_RS1_3   = 32'd7;
  localparam logic [31:0] K_RS2_3   = 32'd3;
  localparam logic [31:0] K_RS1_4   = 32'd3;
  localparam logic [31:0] K_RS2_4   = 32'd1;

  localparam int K_ENC_W = 33;

  // Returns {miss, instr}; an unlisted pair encodes as NOP with miss set.
  function automatic logic [K_ENC_W-1:0] k_encode(input logic [31:0] rs1,
                                                  input logic [31:0] rs2);
    logic [K_ENC_W-1:0] r;
    r = {1'b1, K_INSTR_NOP};
    if (rs1 == K_RS1_NOP && rs2 == K_RS2_NOP) r = {1'b0, K_INSTR_NOP};
    if (rs1 == K_RS1_1   && rs2 == K_RS2_1)   r = {1'b0, K_INSTR_1};
    if (rs1 == K_RS1_2   && rs2 == K_RS2_2)   r = {1'b0, K_INSTR_2};
    if (rs1 == K_RS1_3   && rs2 == K_RS2_3)   r = {1'b0, K_INSTR_3};
    if (rs1 == K_RS1_4   && rs2 == K_RS2_4)   r = {1'b0, K_INSTR_4};
    return r;
  endfunction

endpackage

// File: rtl/k_sync_fifo.sv
// rtl/k_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy output
module k_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == DEPTH[AW:0]);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Storage is not reset, so the head is masked to zero while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/k_encode_logic.sv
// rtl/k_encode_logic.sv - operand-pair to K_DSP instruction encoder with output FIFO and miss counter
module k_encode_logic
  import k_dsp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_rs1,
  input  logic [31:0]              in_rs2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instruction,
  output logic                     out_miss,
  input  logic                     clr_count,
  output logic [CNT_W-1:0]         miss_count,
  output logic [$clog2(DEPTH):0]   level
);

  logic               accept;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [K_ENC_W-1:0] enc;
  logic [K_ENC_W-1:0] head;

  assign enc       = k_encode(in_rs1, in_rs2);
  // Handshake outputs depend only on registered occupancy.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_miss        = head[K_ENC_W-1];
  assign out_instruction = head[31:0];

  k_sync_fifo #(
    .WIDTH (K_ENC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (enc),
    .pop       (pop),
    .pop_data  (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (clr_count) begin
      miss_count <= '0;
    end else if (accept && enc[K_ENC_W-1] && !(&miss_count)) begin
      miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_k_encode_logic.sv
// tb/tb_k_encode_logic.sv - randomized and directed self-checking bench for k_encode_logic
module tb_k_encode_logic;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic        out_ready = 1'b0;
  logic        clr_count = 1'b0;

  logic        in_ready, out_valid, out_miss;
  logic [31:0] out_instruction;
  logic [15:0] miss_count;
  logic [2:0]  level;

  logic        s_in_ready, s_out_valid, s_out_miss;
  logic [31:0] s_out_instruction;
  logic [3:0]  s_miss_count;
  logic [2:0]  s_level;

  always #5 clk = ~clk;

  k_encode_logic #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_miss(out_miss), .clr_count(clr_count),
    .miss_count(miss_count), .level(level)
  );

  k_encode_logic #(.DEPTH(DEPTH), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_instruction(s_out_instruction), .out_miss(s_out_miss), .clr_count(clr_count),
    .miss_count(s_miss_count), .level(s_level)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the legal operand pairs and the codes they encode to.
  int unsigned tbl_rs1 [5] = '{0, 1, 15, 7, 3};
  int unsigned tbl_rs2 [5] = '{0, 15, 7, 3, 1};
  int unsigned tbl_code[5] = '{0, 1, 2, 3, 4};

  function automatic logic [32:0] ref_code(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 5; i++)
      if (a == tbl_rs1[i] && b == tbl_rs2[i]) return {1'b0, tbl_code[i]};
    return {1'b1, 32'd0};
  endfunction

  logic [32:0] q[$];
  logic [32:0] popped[$];
  int mc16 = 0;
  int mc4 = 0;

  task automatic cycle();
    bit acc, pp;
    logic [32:0] e, hd;
    hd = (q.size() != 0) ? q[0] : 33'd0;
    chk("in_ready",   in_ready,        q.size() < DEPTH);
    chk("out_valid",  out_valid,       q.size() != 0);
    chk("level",      level,           q.size());
    chk("out_instr",  out_instruction, hd[31:0]);
    chk("out_miss",   out_miss,        hd[32]);
    chk("miss_count", miss_count,      mc16);
    chk("sat_count",  s_miss_count,    mc4);
    chk("sat_level",  s_level,         q.size());
    acc = in_valid && (q.size() < DEPTH);
    pp  = out_ready && (q.size() != 0);
    e   = ref_code(in_rs1, in_rs2);
    if (pp) popped.push_back({out_miss, out_instruction});
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (clr_count) begin
      mc16 = 0;
      mc4 = 0;
    end else if (acc && e[32]) begin
      if (mc16 < 65535) mc16++;
      if (mc4 < 15) mc4++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic clr);
    in_valid  = v;
    in_rs1    = a;
    in_rs2    = b;
    out_ready = ordy;
    clr_count = clr;
    cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_in_ready",   in_ready, 1);
    chk("rst_out_valid",  out_valid, 0);
    chk("rst_level",      level, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_out_instr",  out_instruction, 0);
    drive(0, 0, 0, 0, 0);

    popped.delete();
    drive(1, 1, 15, 1, 0);
    drive(1, 7, 3, 1, 0);
    drive(1, 15, 7, 1, 0);
    drive(1, 3, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("stream_n", popped.size(), 4);
    if (popped.size() == 4) begin
      chk("stream_0", popped[0], 33'd1);
      chk("stream_1", popped[1], 33'd3);
      chk("stream_2", popped[2], 33'd2);
      chk("stream_3", popped[3], 33'd4);
    end
    chk("stream_mc", miss_count, 0);

    for (int i = 0; i < 4; i++) drive(1, 7, 3, 0, 0);
    chk("bp_level_full", level, 4);
    chk("bp_in_ready",   in_ready, 0);
    drive(1, 5, 5, 0, 0);
    chk("bp_fifth_drop", level, 4);
    chk("bp_fifth_mc",   miss_count, 0);
    drive(1, 1, 15, 1, 0);
    chk("bp_pop_only", level, 3);
    drive(1, 7, 3, 1, 0);
    chk("bp_push_pop", level, 3);
    repeat (4) drive(0, 0, 0, 1, 0);

    popped.delete();
    drive(1, 5, 5, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 14, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("miss_n", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("miss_0", popped[0], {1'b1, 32'd0});
      chk("miss_1", popped[1], {1'b0, 32'd0});
      chk("miss_2", popped[2], {1'b1, 32'd0});
    end
    chk("miss_cnt2", miss_count, 2);
    drive(1, 9, 9, 1, 1);
    chk("miss_clr_wins", miss_count, 0);
    drive(0, 0, 0, 1, 0);

    for (int i = 0; i < 17; i++) drive(1, 100 + i, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("sat_cnt15", s_miss_count, 15);
    chk("sat_wide17", miss_count, 17);

    drive(1, 1, 15, 0, 0);
    drive(1, 3, 1, 0, 0);
    drive(1, 22, 1, 0, 0);
    chk("mid_level3", level, 3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_level",     level, 0);
    chk("mid_out_instr", out_instruction, 0);
    chk("mid_out_miss",  out_miss, 0);
    chk("mid_in_ready",  in_ready, 1);
    chk("mid_mc",        miss_count, 0);
    q.delete();
    mc16 = 0;
    mc4 = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    popped.delete();
    drive(1, 15, 7, 0, 0);
    chk("post_rst_instr", out_instruction, 2);
    chk("post_rst_level", level, 1);
    drive(0, 0, 0, 1, 0);
    chk("post_rst_n", popped.size(), 1);
    if (popped.size() == 1) chk("post_rst_code", popped[0], 33'd2);

    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      logic [31:0] a, b;
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        a = tbl_rs1[sel];
        b = tbl_rs2[sel];
      end else if (sel < 8) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
      end else begin
        a = $urandom;
        b = $urandom;
      end
      drive(1'($urandom_range(0, 3) != 0), a, b,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
